// File: rtl/psum_reduce_ctrl_pkg.sv
// Shared constants and FSM state type for the partial-sum reduction controller.
package psum_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned IN_W  = 11;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned ACC_W = 24;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        HOLD
    } state_e;

endpackage

// File: rtl/psum_reduce_ctrl_sum_tree8.sv
// Combinational 8-lane unsigned adder tree: three pairwise levels, zero-extended to SUM_W.
module sum_tree8
    import psum_pkg::*;
#(
    parameter int unsigned IN_W  = psum_pkg::IN_W,
    parameter int unsigned SUM_W = psum_pkg::SUM_W
) (
    input  logic [8*IN_W-1:0] lanes,
    output logic [SUM_W-1:0]  sum
);

    logic [IN_W:0]   lvl1 [4];
    logic [IN_W+1:0] lvl2 [2];
    logic [IN_W+2:0] lvl3;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lvl1[i] = {1'b0, lanes[IN_W*(2*i) +: IN_W]}
                    + {1'b0, lanes[IN_W*(2*i+1) +: IN_W]};
        end
        for (int unsigned i = 0; i < 2; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
        sum  = SUM_W'(lvl3);
    end

endmodule

// File: rtl/psum_reduce_ctrl.sv
// Beat sequencer: reduces each 8-lane beat through a registered tree stage,
// accumulates a configurable number of beats, and holds the result on a valid/ready port.
module psum_reduce_ctrl
    import psum_pkg::*;
#(
    parameter int unsigned LANES = psum_pkg::LANES,
    parameter int unsigned IN_W  = psum_pkg::IN_W,
    parameter int unsigned SUM_W = psum_pkg::SUM_W,
    parameter int unsigned ACC_W = psum_pkg::ACC_W,
    parameter int unsigned CNT_W = psum_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      cfg_beats,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_ovf,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic               s1_vld_q, s1_vld_d;
    logic [SUM_W-1:0]   s1_sum_q, s1_sum_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [SUM_W-1:0]   tree_sum;
    logic               accept;
    logic [ACC_W:0]     add_w;
    logic [CNT_W-1:0]   cfg_eff;
    logic [CNT_W-1:0]   cnt_inc;

    sum_tree8 #(
        .IN_W  (IN_W),
        .SUM_W (SUM_W)
    ) u_tree (
        .lanes (in_data),
        .sum   (tree_sum)
    );

    // Ready depends only on registered state (and reset), never on in_valid/out_ready.
    assign in_ready = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        s1_vld_d = accept;
        s1_sum_d = accept ? tree_sum : s1_sum_q;
        add_w    = {1'b0, acc_q} + (ACC_W+1)'(s1_sum_q);
        cfg_eff  = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
        cnt_inc  = cnt_q + 1'b1;

        if (s1_vld_q) begin
            acc_d = add_w[ACC_W-1:0];
            ovf_d = ovf_q | add_w[ACC_W];
        end

        case (state_q)
            IDLE: begin
                acc_d = '0;
                if (accept) begin
                    tgt_d   = cfg_eff;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (cfg_eff == CNT_W'(1)) ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == tgt_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            s1_vld_q    <= s1_vld_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_psum_reduce_ctrl.sv
// Self-checking bench: a transaction-level model predicts handshakes and results for a
// 24-bit and a 16-bit accumulator instance driven with identical directed stimulus.
module tb_psum_reduce_ctrl;
    import psum_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [CNT_W-1:0]      cfg_beats = '0;
    logic                  in_valid = 1'b0;
    logic [LANES*IN_W-1:0] in_data = '0;
    logic                  out_ready = 1'b0;

    logic                  a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [23:0]           a_out_sum;
    logic                  b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [15:0]           b_out_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_reduce_ctrl dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_sum   (a_out_sum),
        .out_ovf   (a_out_ovf),
        .busy      (a_busy)
    );

    psum_reduce_ctrl #(.ACC_W(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_sum   (b_out_sum),
        .out_ovf   (b_out_ovf),
        .busy      (b_busy)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    function automatic longint unsigned lane_total(input logic [LANES*IN_W-1:0] d);
        longint unsigned s = 0;
        for (int k = 0; k < 8; k++) s += longint'((d >> (11*k)) & 88'h7FF);
        return s;
    endfunction

    function automatic logic [LANES*IN_W-1:0] lanes_all(input int unsigned v);
        logic [LANES*IN_W-1:0] d = '0;
        for (int k = 0; k < 8; k++) d[11*k +: 11] = 11'(v);
        return d;
    endfunction

    function automatic logic [LANES*IN_W-1:0] lanes_ramp();
        logic [LANES*IN_W-1:0] d = '0;
        for (int k = 0; k < 8; k++) d[11*k +: 11] = 11'(k + 1);
        return d;
    endfunction

    // Transaction model: beats counted per result, result presented one edge after the
    // edge following the last accepted beat, held until out_ready.
    int unsigned     m_cnt = 0, m_tgt = 0;
    bit              m_pend = 0, m_hold = 0, m_acc = 0;
    int              m_wait = 0;
    longint unsigned m_sum = 0, m_res = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_tgt = 0; m_pend = 0; m_hold = 0; m_wait = 0; m_sum = 0; m_res = 0;
        end else begin
            m_acc = in_valid && !m_pend;
            if (m_hold && out_ready) begin
                m_hold = 0;
                m_pend = 0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_hold = 1;
            end
            if (m_acc) begin
                if (m_cnt == 0) begin
                    m_tgt = (cfg_beats == 0) ? 1 : int'(cfg_beats);
                    m_sum = 0;
                end
                m_sum += lane_total(in_data);
                m_cnt++;
                if (m_cnt == m_tgt) begin
                    m_pend = 1;
                    m_wait = 1;
                    m_cnt  = 0;
                    m_res  = m_sum;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("a.in_ready", a_in_ready, rst_n && !m_pend);
        chk("b.in_ready", b_in_ready, rst_n && !m_pend);
        chk("a.out_valid", a_out_valid, m_hold);
        chk("b.out_valid", b_out_valid, m_hold);
        chk("a.busy", a_busy, m_pend || (m_cnt != 0));
        chk("b.busy", b_busy, m_pend || (m_cnt != 0));
        if (m_hold) begin
            chk("a.out_sum", a_out_sum, m_res % (64'd1 << 24));
            chk("a.out_ovf", a_out_ovf, m_res >= (64'd1 << 24));
            chk("b.out_sum", b_out_sum, m_res % (64'd1 << 16));
            chk("b.out_ovf", b_out_ovf, m_res >= (64'd1 << 16));
        end else if (!m_pend && m_cnt == 0) begin
            chk("a.idle_sum", a_out_sum, 0);
            chk("b.idle_sum", b_out_sum, 0);
        end
    end

    task automatic send(input logic [LANES*IN_W-1:0] d, input int unsigned c);
        int n = 0;
        in_data   = d;
        cfg_beats = CNT_W'(c);
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (a_in_ready) break;
            n++;
            if (n > 20) begin
                timeout("send");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string nm, input int hold,
                              input longint unsigned e24, input bit o24,
                              input longint unsigned e16, input bit o16,
                              output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (a_out_valid) break;
            if (lat > 20) begin
                timeout(nm);
                break;
            end
        end
        chk({nm, ".sum24"}, a_out_sum, e24);
        chk({nm, ".ovf24"}, a_out_ovf, o24);
        chk({nm, ".sum16"}, b_out_sum, e16);
        chk({nm, ".ovf16"}, b_out_ovf, o16);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".held_sum"}, a_out_sum, e24);
            chk({nm, ".held_ready"}, a_in_ready, 0);
            chk({nm, ".held_busy"}, a_busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        int lat;
        #12;
        chk("rst.out_valid", a_out_valid, 0);
        chk("rst.in_ready", a_in_ready, 0);
        chk("rst.busy", a_busy, 0);
        chk("rst.out_sum", a_out_sum, 0);
        chk("rst.out_ovf", a_out_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(lanes_all(1), 1);
        get_result("single", 0, 8, 0, 8, 0, lat);
        chk("single.latency", lat, 2);

        for (int i = 0; i < 3; i++) send(lanes_ramp(), 3);
        get_result("ramp", 0, 108, 0, 108, 0, lat);

        for (int i = 0; i < 4; i++) send(lanes_all(2047), 4);
        get_result("max4", 0, 65504, 0, 65504, 0, lat);

        for (int i = 0; i < 5; i++) send(lanes_all(2047), 5);
        get_result("max5", 0, 81880, 0, 16344, 1, lat);

        for (int i = 0; i < 2; i++) send(lanes_all(3), 2);
        in_valid = 1'b1;
        in_data  = lanes_all(9);
        get_result("bp", 5, 48, 0, 48, 0, lat);
        @(negedge clk);
        chk("bp.ready_after", a_in_ready, 1);
        chk("bp.busy_after", a_busy, 0);
        @(posedge clk); #1;
        send(lanes_all(7), 1);
        get_result("bp_next", 0, 56, 0, 56, 0, lat);

        send(lanes_all(2), 0);
        get_result("cfg0", 0, 16, 0, 16, 0, lat);

        for (int i = 0; i < 2; i++) send(lanes_all(5), 2);
        get_result("b2b", 0, 80, 0, 80, 0, lat);
        send(lanes_all(5), 2);
        repeat (3) @(posedge clk);
        #1;
        send(lanes_all(5), 2);
        get_result("gap", 0, 80, 0, 80, 0, lat);

        send(lanes_all(4), 2);
        send(lanes_all(4), 7);
        get_result("cfg_change", 0, 64, 0, 64, 0, lat);

        for (int i = 0; i < 2; i++) send(lanes_all(1), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", a_out_valid, 0);
        chk("midrst.busy", a_busy, 0);
        chk("midrst.b_busy", b_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(lanes_all(1), 4);
        get_result("post_rst", 0, 32, 0, 32, 0, lat);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_reduce_ctrl.md
# psum_reduce_ctrl

- Sequencing controller for the 8-lane partial-sum adder tree.
- Accepts a configurable number of 8×11-bit partial-sum beats over a valid/ready handshake.
- Reduces each beat through a registered 16-bit tree stage, accumulates the beats into one wide result, and holds that result on an output valid/ready port.
- Sits between the systolic-array column drain and the result writeback path.

## Interface

Parameters:
- LANES, 8, partial sums per beat (fixed at 8 for the tree).
- IN_W, 11, width of each lane, unsigned.
- SUM_W, 16, tree output width.
- ACC_W, 24, accumulator and result width.
- CNT_W, 8, width of the beat count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_beats  in  CNT_W  beats per result; sampled only on the first accepted beat. Value 0 is treated as 1.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  LANES*IN_W  lane k occupies bits [IN_W*(k+1)-1 : IN_W*k].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  ACC_W  accumulated result.
- out_ovf  out  1  accumulator wrapped during this result; valid with out_valid.
- busy  out  1  high in any state other than IDLE.

## Operation

- All data is unsigned. The tree sums exactly 8 distinct lanes (0..7), each once.
- Tree result is zero-extended to SUM_W. Accumulator adds it zero-extended to ACC_W, modulo 2^ACC_W.
- A carry out of ACC_W sets the sticky ovf bit, which is cleared at the start of each result.

State machine:
- IDLE
  - in_ready = 1; accumulator = 0.
  - On accept: latch beats_tgt = max(cfg_beats, 1), set cnt = 1, clear ovf.
  - If beats_tgt == 1, go to FLUSH; otherwise go to ACCUM.
- ACCUM
  - in_ready = 1.
  - Each accept increments cnt.
  - When the accept makes cnt == beats_tgt, go to FLUSH.
  - Gaps on in_valid are allowed indefinitely.
- FLUSH
  - in_ready = 0.
  - The stage-1 register drains its final beat into the accumulator, then the block goes to HOLD.
  - FLUSH always lasts exactly 1 cycle.
- HOLD
  - out_valid = 1; out_sum and out_ovf are stable.
  - On out_ready, go to IDLE. The accumulator clears on that same edge.

Pipeline:
- Stage 1 registers the tree sum plus a valid bit on every accept.
- Whenever stage-1 valid is set, the accumulator adds the stage-1 sum on the next edge.

Reset:
- rst_n low forces IDLE, clears the accumulator, count, stage-1 valid and ovf, and drops any partial result.
- Reset values: in_ready = 0 while rst_n is low and 1 after release; out_valid = 0, out_sum = 0, out_ovf = 0, busy = 0.

## Timing

- Latency: last beat accepted at edge E0 → accumulator final at E1 → out_valid high in the cycle after E1, i.e. 2 edges after the last accept.
- Throughput: one beat per cycle within a result.
- Minimum gap between results: FLUSH (1 cycle) + HOLD (≥1 cycle) + the first beat of the next result in IDLE.
- in_ready is registered-state-derived only; it has no combinational path from in_valid or out_ready.
- out_valid is a register output. It never drops without a handshake, and out_sum does not change while out_valid && !out_ready.
- cfg_beats changes are ignored after the first beat of a result.

## Structure

Shared package psum_pkg holds:
- LANES, IN_W, SUM_W, ACC_W, CNT_W;
- the state enum {IDLE, ACCUM, FLUSH, HOLD}.

Sub-module sum_tree8:
- Purely combinational, 8 × IN_W → SUM_W.
- Three levels of pairwise adders.
- Instanced once, feeding the stage-1 register.

All remaining logic (FSM, counter, stage-1 register, accumulator, output register) lives in psum_reduce_ctrl.

## Test plan

- Single-beat result:
  - Stimulus: cfg_beats=1, all lanes=1, out_ready=1.
  - Required: out_sum=8, out_valid high exactly 2 edges after the accept, out_ovf=0.
- Lane-distinct check:
  - Stimulus: lane k = k+1, cfg_beats=3, three consecutive beats.
  - Required: out_sum=108. Any lane dropped or duplicated yields a different value.
- Max values:
  - Stimulus: all lanes=2047, cfg_beats=4.
  - Required: out_sum=65504.
  - Repeat with ACC_W=16: out_sum=65504 with ovf=0. Then cfg_beats=5: out_sum=(81880 mod 65536)=16344, out_ovf=1.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles in HOLD; in_valid held high throughout.
  - Required: out_sum stable, in_ready=0, busy=1. After out_ready, IDLE and in_ready=1 on the next cycle. The next result is independent (accumulator restarts from 0).
- cfg_beats=0 and in_valid gaps:
  - Stimulus: cfg_beats=0 with lanes=2.
  - Required: result 16 after one beat.
  - Stimulus: cfg_beats=2 with a 3-cycle in_valid gap between the two beats.
  - Required: same value as back-to-back beats.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low after 2 of 4 beats.
  - Required: out_valid=0, busy=0 immediately. The next 4-beat result of lanes=1 gives out_sum=32 (no stale accumulation).
